// File: rtl/controle_jogo_seq.sv
`default_nettype none
// ============================================================================
// Module      : controle_jogo_seq
// Description : Control unit for the sequence-memory game. Holds the round,
//               address, timer and play registers, drives the external
//               sequence memory and the LED bank, and evaluates the debounced
//               button plays coming from the datapath. In modo=1 the player
//               enters each new sequence element, which is written to memory.
//
// Ports       : clock            system clock, rising edge
//               reset            synchronous active-high reset
//               iniciar          start/restart request
//               modo             0 = sequence from memory, 1 = player appends
//               jogada           one-cycle valid pulse for botoes
//               botoes           one-hot button code
//               mem_dado         memory read data at mem_endereco
//               mem_endereco     memory address (address counter)
//               mem_escreve      one-cycle memory write strobe
//               mem_dado_escrita memory write data (play register)
//               leds             LED drive (memory data while showing)
//               rodada           current round r (sequence length r+1)
//               acertou          game won
//               errou            wrong play or timeout
//               timeout_flag     play timeout
//               pronto           game finished (won, lost or timed out)
//               db_estado        current state code
//
// Revision    : 1.0 - initial parametrised release
// ============================================================================
module controle_jogo_seq #(
    parameter int N_ROUNDS       = 16,
    parameter int ADDR_W         = 4,
    parameter int DATA_W         = 4,
    parameter int LED_ON_CYCLES  = 1000,
    parameter int LED_GAP_CYCLES = 250,
    parameter int TIMEOUT_CYCLES = 5000
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              iniciar,
    input  logic              modo,
    input  logic              jogada,
    input  logic [DATA_W-1:0] botoes,
    input  logic [DATA_W-1:0] mem_dado,
    output logic [ADDR_W-1:0] mem_endereco,
    output logic              mem_escreve,
    output logic [DATA_W-1:0] mem_dado_escrita,
    output logic [DATA_W-1:0] leds,
    output logic [ADDR_W-1:0] rodada,
    output logic              acertou,
    output logic              errou,
    output logic              timeout_flag,
    output logic              pronto,
    output logic [3:0]        db_estado
);

    // Timer is sized for the longest of the three timed intervals.
    localparam int c_MAX_AB     = (LED_ON_CYCLES > LED_GAP_CYCLES) ? LED_ON_CYCLES : LED_GAP_CYCLES;
    localparam int c_MAX_CYCLES = (c_MAX_AB > TIMEOUT_CYCLES) ? c_MAX_AB : TIMEOUT_CYCLES;
    localparam int c_TMR_W      = (c_MAX_CYCLES > 1) ? $clog2(c_MAX_CYCLES) : 1;

    localparam logic [c_TMR_W-1:0] c_ON_LAST  = c_TMR_W'(LED_ON_CYCLES - 1);
    localparam logic [c_TMR_W-1:0] c_GAP_LAST = c_TMR_W'(LED_GAP_CYCLES - 1);
    localparam logic [c_TMR_W-1:0] c_TO_LAST  = c_TMR_W'(TIMEOUT_CYCLES - 1);
    localparam logic [ADDR_W-1:0]  c_LAST_RND = ADDR_W'(N_ROUNDS - 1);

    localparam logic [3:0] c_INICIAL       = 4'd0;
    localparam logic [3:0] c_PREPARA       = 4'd1;
    localparam logic [3:0] c_INICIA_RODADA = 4'd2;
    localparam logic [3:0] c_MOSTRA_LED    = 4'd3;
    localparam logic [3:0] c_INTERVALO     = 4'd4;
    localparam logic [3:0] c_ESPERA        = 4'd5;
    localparam logic [3:0] c_COMPARA       = 4'd6;
    localparam logic [3:0] c_PROXIMA       = 4'd7;
    localparam logic [3:0] c_FIM_RODADA    = 4'd8;
    localparam logic [3:0] c_ESPERA_NOVA   = 4'd9;
    localparam logic [3:0] c_GRAVA         = 4'd10;
    localparam logic [3:0] c_TIMEOUT       = 4'd13;
    localparam logic [3:0] c_ERRO          = 4'd14;
    localparam logic [3:0] c_ACERTO        = 4'd15;

    logic [3:0]         r_estado;
    logic [ADDR_W-1:0]  r_rodada;
    logic [ADDR_W-1:0]  r_endereco;
    logic [c_TMR_W-1:0] r_timer;
    logic [DATA_W-1:0]  r_jogada;
    logic               r_modo;

    logic w_fim_rodada;
    assign w_fim_rodada = (r_endereco == r_rodada);

    always_ff @(posedge clock) begin
        if (reset) begin
            r_estado   <= c_INICIAL;
            r_rodada   <= '0;
            r_endereco <= '0;
            r_timer    <= '0;
            r_jogada   <= '0;
            r_modo     <= 1'b0;
        end else begin
            case (r_estado)
                c_INICIAL: begin
                    if (iniciar) begin
                        r_estado <= c_PREPARA;
                    end
                end
                c_PREPARA: begin
                    r_rodada   <= '0;
                    r_endereco <= '0;
                    r_jogada   <= '0;
                    r_timer    <= '0;
                    r_modo     <= modo;
                    r_estado   <= modo ? c_ESPERA_NOVA : c_INICIA_RODADA;
                end
                c_INICIA_RODADA: begin
                    r_endereco <= '0;
                    r_timer    <= '0;
                    r_estado   <= c_MOSTRA_LED;
                end
                c_MOSTRA_LED: begin
                    if (r_timer == c_ON_LAST) begin
                        r_timer  <= '0;
                        r_estado <= c_INTERVALO;
                    end else begin
                        r_timer <= r_timer + 1'b1;
                    end
                end
                c_INTERVALO: begin
                    if (r_timer == c_GAP_LAST) begin
                        r_timer <= '0;
                        if (w_fim_rodada) begin
                            r_endereco <= '0;
                            r_estado   <= c_ESPERA;
                        end else begin
                            r_endereco <= r_endereco + 1'b1;
                            r_estado   <= c_MOSTRA_LED;
                        end
                    end else begin
                        r_timer <= r_timer + 1'b1;
                    end
                end
                c_ESPERA, c_ESPERA_NOVA: begin
                    // A play arriving on the terminal timer count still counts.
                    if (jogada) begin
                        r_jogada <= botoes;
                        r_timer  <= '0;
                        r_estado <= (r_estado == c_ESPERA) ? c_COMPARA : c_GRAVA;
                    end else if (r_timer == c_TO_LAST) begin
                        r_timer  <= '0;
                        r_estado <= c_TIMEOUT;
                    end else begin
                        r_timer <= r_timer + 1'b1;
                    end
                end
                c_COMPARA: begin
                    if (r_jogada != mem_dado) begin
                        r_estado <= c_ERRO;
                    end else if (w_fim_rodada) begin
                        r_estado <= c_FIM_RODADA;
                    end else begin
                        r_estado <= c_PROXIMA;
                    end
                end
                c_PROXIMA: begin
                    r_endereco <= r_endereco + 1'b1;
                    r_timer    <= '0;
                    r_estado   <= c_ESPERA;
                end
                c_FIM_RODADA: begin
                    if (r_rodada == c_LAST_RND) begin
                        r_estado <= c_ACERTO;
                    end else begin
                        r_rodada <= r_rodada + 1'b1;
                        r_timer  <= '0;
                        if (r_modo) begin
                            // The new element lands at the new round's index.
                            r_endereco <= r_rodada + 1'b1;
                            r_estado   <= c_ESPERA_NOVA;
                        end else begin
                            r_estado <= c_INICIA_RODADA;
                        end
                    end
                end
                c_GRAVA: begin
                    r_estado <= c_INICIA_RODADA;
                end
                c_TIMEOUT, c_ERRO, c_ACERTO: begin
                    // Clear on the way into PREPARA so the round reads 0 there.
                    if (iniciar) begin
                        r_rodada   <= '0;
                        r_endereco <= '0;
                        r_jogada   <= '0;
                        r_timer    <= '0;
                        r_estado   <= c_PREPARA;
                    end
                end
                default: begin
                    r_rodada   <= '0;
                    r_endereco <= '0;
                    r_jogada   <= '0;
                    r_timer    <= '0;
                    r_estado   <= c_INICIAL;
                end
            endcase
        end
    end

    assign mem_endereco     = r_endereco;
    assign mem_dado_escrita = r_jogada;
    assign rodada           = r_rodada;
    assign db_estado        = r_estado;
    assign mem_escreve      = (r_estado == c_GRAVA);
    assign leds             = (r_estado == c_MOSTRA_LED) ? mem_dado : '0;
    assign acertou          = (r_estado == c_ACERTO);
    assign timeout_flag     = (r_estado == c_TIMEOUT);
    assign errou            = (r_estado == c_ERRO) || (r_estado == c_TIMEOUT);
    assign pronto           = (r_estado == c_ACERTO) || (r_estado == c_ERRO) ||
                              (r_estado == c_TIMEOUT);

endmodule
`default_nettype wire

// File: tb/tb_controle_jogo_seq.sv
`default_nettype none
// ============================================================================
// Module      : tb_controle_jogo_seq
// Description : Self-checking bench for controle_jogo_seq with a small
//               behavioural sequence memory and scoreboard queues.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_controle_jogo_seq;

    localparam int N_ROUNDS = 4;
    localparam int ADDR_W   = 2;
    localparam int DATA_W   = 4;

    logic              clock = 1'b0;
    logic              reset;
    logic              iniciar;
    logic              modo;
    logic              jogada;
    logic [DATA_W-1:0] botoes;
    logic [DATA_W-1:0] mem_dado;
    logic [ADDR_W-1:0] mem_endereco;
    logic              mem_escreve;
    logic [DATA_W-1:0] mem_dado_escrita;
    logic [DATA_W-1:0] leds;
    logic [ADDR_W-1:0] rodada;
    logic              acertou;
    logic              errou;
    logic              timeout_flag;
    logic              pronto;
    logic [3:0]        db_estado;

    int checks   = 0;
    int failures = 0;

    logic [DATA_W-1:0] q_led[$];
    logic [5:0]        q_wr[$];
    logic [5:0]        q_res[$];

    // Sequence memory model
    logic [DATA_W-1:0] mem      [N_ROUNDS];
    logic [DATA_W-1:0] mem_init [N_ROUNDS];
    logic              mem_load = 1'b0;

    always #5 clock = ~clock;

    always @(posedge clock) begin
        if (mem_load) begin
            for (int i = 0; i < N_ROUNDS; i++) mem[i] <= mem_init[i];
        end else if (mem_escreve) begin
            mem[mem_endereco] <= mem_dado_escrita;
        end
    end
    assign mem_dado = mem[mem_endereco];

    controle_jogo_seq #(
        .N_ROUNDS(N_ROUNDS), .ADDR_W(ADDR_W), .DATA_W(DATA_W),
        .LED_ON_CYCLES(3), .LED_GAP_CYCLES(2), .TIMEOUT_CYCLES(10)
    ) dut (
        .clock(clock), .reset(reset), .iniciar(iniciar), .modo(modo),
        .jogada(jogada), .botoes(botoes), .mem_dado(mem_dado),
        .mem_endereco(mem_endereco), .mem_escreve(mem_escreve),
        .mem_dado_escrita(mem_dado_escrita), .leds(leds), .rodada(rodada),
        .acertou(acertou), .errou(errou), .timeout_flag(timeout_flag),
        .pronto(pronto), .db_estado(db_estado)
    );

    task automatic load_mem(input logic [3:0] a, input logic [3:0] b,
                            input logic [3:0] c, input logic [3:0] d);
        mem_init[0] = a; mem_init[1] = b; mem_init[2] = c; mem_init[3] = d;
        mem_load = 1'b1;
        @(negedge clock);
        mem_load = 1'b0;
    endtask

    task automatic do_reset();
        reset = 1'b1; iniciar = 1'b0; jogada = 1'b0; botoes = '0; modo = 1'b0;
        repeat (2) @(negedge clock);
        reset = 1'b0;
    endtask

    task automatic start_game(input logic m);
        modo = m;
        iniciar = 1'b1;
        @(negedge clock);
        iniciar = 1'b0;
    endtask

    task automatic wait_for(input logic [3:0] s, input int budget, output logic ok);
        ok = (db_estado === s);
        for (int i = 0; i < budget && !ok; i++) begin
            @(negedge clock);
            if (db_estado === s) ok = 1'b1;
        end
    endtask

    task automatic test_reset();
        reset = 1'b1; iniciar = 1'b0; jogada = 1'b0; botoes = '0; modo = 1'b0;
        mem_init[0] = 4'b0001; mem_init[1] = 4'b0010;
        mem_init[2] = 4'b0100; mem_init[3] = 4'b1000;
        mem_load = 1'b1;
        @(negedge clock);
        mem_load = 1'b0;
        @(negedge clock);
        checks++;
        if (db_estado !== 4'd0) begin
            failures++; $display("FAIL reset_state got %0d expected 0", db_estado);
        end
        checks++;
        if (mem_escreve !== 1'b0) begin
            failures++; $display("FAIL reset_mem_escreve got %b expected 0", mem_escreve);
        end
        checks++;
        if ({mem_endereco, mem_dado_escrita, leds, rodada, acertou, errou, timeout_flag, pronto} !== '0) begin
            failures++;
            $display("FAIL reset_outputs got %h expected 0",
                     {mem_endereco, mem_dado_escrita, leds, rodada, acertou, errou, timeout_flag, pronto});
        end
        reset = 1'b0;
    endtask

    task automatic test_modo0_win();
        int k, run, windows, dark;
        logic [3:0] prev;
        logic [3:0] cur;
        do_reset();
        q_led.delete();
        for (int r = 0; r < N_ROUNDS; r++)
            for (int a = 0; a <= r; a++) q_led.push_back(mem_init[a]);
        start_game(1'b0);
        prev = 4'd1; k = 0; run = 0; windows = 0; dark = 0; cur = '0;
        for (int cyc = 0; cyc < 400 && pronto !== 1'b1; cyc++) begin
            @(negedge clock);
            jogada = 1'b0;
            if (db_estado == 4'd2) k = 0;
            if (db_estado == 4'd3) begin
                if (prev != 4'd3) begin
                    windows++; run = 0;
                    checks++;
                    if (q_led.size() == 0) begin
                        failures++; $display("FAIL led_extra_window got window %0d expected none", windows);
                    end else cur = q_led.pop_front();
                end
                run++;
                checks++;
                if (leds !== cur) begin
                    failures++; $display("FAIL led_value got %b expected %b", leds, cur);
                end
            end
            if (prev == 4'd3 && db_estado != 4'd3) begin
                checks++;
                if (run != 3) begin
                    failures++; $display("FAIL led_on_len got %0d expected 3", run);
                end
            end
            if (db_estado == 4'd4) begin
                dark++;
                checks++;
                if (leds !== 4'b0000) begin
                    failures++; $display("FAIL led_gap_dark got %b expected 0000", leds);
                end
            end
            if (db_estado == 4'd5) begin
                jogada = 1'b1;
                botoes = mem_init[k[1:0]];
                k++;
            end
            prev = db_estado;
        end
        jogada = 1'b0;
        checks++;
        if (db_estado !== 4'd15) begin
            failures++; $display("FAIL win_state got %0d expected 15", db_estado);
        end
        checks++;
        if ({acertou, pronto, errou, timeout_flag} !== 4'b1100) begin
            failures++; $display("FAIL win_flags got %b expected 1100", {acertou, pronto, errou, timeout_flag});
        end
        checks++;
        if (rodada !== 2'd3) begin
            failures++; $display("FAIL win_rodada got %0d expected 3", rodada);
        end
        checks++;
        if (windows != 10 || q_led.size() != 0) begin
            failures++; $display("FAIL win_windows got %0d expected 10", windows);
        end
        checks++;
        if (dark != 20) begin
            failures++; $display("FAIL win_dark_cycles got %0d expected 20", dark);
        end
        checks++;
        if (leds !== 4'b0000) begin
            failures++; $display("FAIL win_leds got %b expected 0000", leds);
        end
    endtask

    task automatic test_erro();
        int k;
        logic [5:0] exp;
        do_reset();
        q_res.delete();
        start_game(1'b0);
        k = 0;
        for (int cyc = 0; cyc < 400 && pronto !== 1'b1; cyc++) begin
            @(negedge clock);
            jogada = 1'b0;
            if (db_estado == 4'd2) k = 0;
            if (db_estado == 4'd5) begin
                jogada = 1'b1;
                if (rodada == 2'd2 && k == 1) begin
                    botoes = 4'b0100;
                    q_res.push_back({4'd14, 2'd2});
                end else begin
                    botoes = mem_init[k[1:0]];
                end
                k++;
            end
        end
        jogada = 1'b0;
        checks++;
        if (q_res.size() == 0) begin
            failures++; $display("FAIL erro_no_wrong_play got state %0d expected wrong play at round 2", db_estado);
        end else begin
            exp = q_res.pop_front();
            if ({db_estado, rodada} !== exp) begin
                failures++; $display("FAIL erro_state_rodada got %0d/%0d expected %0d/%0d",
                                     db_estado, rodada, exp[5:2], exp[1:0]);
            end
        end
        checks++;
        if ({errou, pronto, acertou, timeout_flag} !== 4'b1100) begin
            failures++; $display("FAIL erro_flags got %b expected 1100", {errou, pronto, acertou, timeout_flag});
        end
        iniciar = 1'b1;
        @(negedge clock);
        iniciar = 1'b0;
        checks++;
        if ({db_estado, rodada} !== {4'd1, 2'd0}) begin
            failures++; $display("FAIL erro_restart got %0d/%0d expected 1/0", db_estado, rodada);
        end
    endtask

    task automatic test_timeout();
        logic ok;
        int n;
        logic done;
        logic [5:0] exp;
        do_reset();
        q_res.delete();
        start_game(1'b0);
        wait_for(4'd5, 100, ok);
        checks++;
        if (!ok) begin
            failures++; $display("FAIL to_reach_espera got %0d expected 5", db_estado);
        end
        q_res.push_back({4'd13, 2'd0});
        n = 1; done = 1'b0;
        for (int i = 0; i < 40 && !done; i++) begin
            @(negedge clock);
            if (db_estado == 4'd5) n++;
            else done = 1'b1;
        end
        checks++;
        if (n != 10) begin
            failures++; $display("FAIL to_wait_cycles got %0d expected 10", n);
        end
        exp = q_res.pop_front();
        checks++;
        if ({db_estado, rodada} !== exp) begin
            failures++; $display("FAIL to_state got %0d expected %0d", db_estado, exp[5:2]);
        end
        checks++;
        if ({timeout_flag, errou, pronto, acertou} !== 4'b1110) begin
            failures++; $display("FAIL to_flags got %b expected 1110", {timeout_flag, errou, pronto, acertou});
        end
        // Play on the last allowed cycle must win over the timeout.
        do_reset();
        start_game(1'b0);
        wait_for(4'd5, 100, ok);
        repeat (9) @(negedge clock);
        checks++;
        if (db_estado !== 4'd5) begin
            failures++; $display("FAIL to_tenth_cycle got %0d expected 5", db_estado);
        end
        jogada = 1'b1;
        botoes = mem_init[0];
        @(negedge clock);
        jogada = 1'b0;
        checks++;
        if ({db_estado, timeout_flag} !== {4'd6, 1'b0}) begin
            failures++; $display("FAIL to_late_play got %0d/%b expected 6/0", db_estado, timeout_flag);
        end
        @(negedge clock);
        checks++;
        if (db_estado !== 4'd8) begin
            failures++; $display("FAIL to_late_play_fim got %0d expected 8", db_estado);
        end
    endtask

    task automatic test_modo1();
        logic ok;
        int ws, run, windows;
        logic [3:0] prev;
        logic [3:0] cur;
        logic [5:0] exp;
        do_reset();
        load_mem(4'b0, 4'b0, 4'b0, 4'b0);
        q_wr.delete(); q_led.delete();
        start_game(1'b1);
        wait_for(4'd9, 20, ok);
        checks++;
        if (!ok || mem_endereco !== 2'd0 || rodada !== 2'd0) begin
            failures++; $display("FAIL m1_espera_nova got %0d/%0d/%0d expected 9/0/0", db_estado, mem_endereco, rodada);
        end
        jogada = 1'b1;
        botoes = 4'b0010;
        q_wr.push_back({2'd0, 4'b0010});
        q_led.push_back(4'b0010);
        @(negedge clock);
        jogada = 1'b0;
        checks++;
        if ({db_estado, mem_escreve} !== {4'd10, 1'b1}) begin
            failures++; $display("FAIL m1_grava got %0d/%b expected 10/1", db_estado, mem_escreve);
        end
        exp = q_wr.pop_front();
        checks++;
        if ({mem_endereco, mem_dado_escrita} !== exp) begin
            failures++; $display("FAIL m1_write got %0d/%b expected %0d/%b", mem_endereco, mem_dado_escrita, exp[5:4], exp[3:0]);
        end
        ws = 0; run = 0; windows = 0; prev = 4'd10; cur = '0;
        for (int cyc = 0; cyc < 100 && db_estado !== 4'd9; cyc++) begin
            @(negedge clock);
            jogada = 1'b0;
            if (mem_escreve) ws++;
            if (db_estado == 4'd3) begin
                if (prev != 4'd3) begin
                    windows++; run = 0;
                    if (q_led.size() != 0) cur = q_led.pop_front();
                end
                run++;
                checks++;
                if (leds !== cur) begin
                    failures++; $display("FAIL m1_led got %b expected %b", leds, cur);
                end
            end
            if (db_estado == 4'd5) begin
                jogada = 1'b1;
                botoes = 4'b0010;
            end
            prev = db_estado;
        end
        jogada = 1'b0;
        checks++;
        if (ws != 0) begin
            failures++; $display("FAIL m1_extra_writes got %0d expected 0", ws);
        end
        checks++;
        if (windows != 1 || run != 3) begin
            failures++; $display("FAIL m1_led_window got %0d windows/%0d cycles expected 1/3", windows, run);
        end
        checks++;
        if ({db_estado, mem_endereco, rodada} !== {4'd9, 2'd1, 2'd1}) begin
            failures++; $display("FAIL m1_next_round got %0d/%0d/%0d expected 9/1/1", db_estado, mem_endereco, rodada);
        end
    endtask

    task automatic test_ignore();
        logic ok;
        do_reset();
        load_mem(4'b0001, 4'b0010, 4'b0100, 4'b1000);
        start_game(1'b0);
        wait_for(4'd3, 20, ok);
        checks++;
        if (!ok || leds !== 4'b0001) begin
            failures++; $display("FAIL ig_first_led got %0d/%b expected 3/0001", db_estado, leds);
        end
        jogada = 1'b1;
        botoes = 4'b1000;
        @(negedge clock);
        jogada = 1'b0;
        checks++;
        if (db_estado !== 4'd3) begin
            failures++; $display("FAIL ig_jogada_in_led got %0d expected 3", db_estado);
        end
        @(negedge clock);
        @(negedge clock);
        checks++;
        if ({db_estado, mem_dado_escrita} !== {4'd4, 4'b0000}) begin
            failures++; $display("FAIL ig_led_end got %0d/%b expected 4/0000", db_estado, mem_dado_escrita);
        end
        wait_for(4'd5, 20, ok);
        iniciar = 1'b1;
        @(negedge clock);
        iniciar = 1'b0;
        checks++;
        if (db_estado !== 4'd5) begin
            failures++; $display("FAIL ig_iniciar_in_espera got %0d expected 5", db_estado);
        end
        jogada = 1'b1;
        botoes = 4'b0001;
        @(negedge clock);
        jogada = 1'b0;
        wait_for(4'd3, 20, ok);
        checks++;
        if (!ok || rodada !== 2'd1 || leds !== 4'b0001) begin
            failures++; $display("FAIL ig_round1_led got %0d/%0d/%b expected 3/1/0001", db_estado, rodada, leds);
        end
        reset = 1'b1;
        @(negedge clock);
        reset = 1'b0;
        checks++;
        if ({db_estado, leds, rodada, mem_endereco} !== '0) begin
            failures++; $display("FAIL ig_reset_in_led got %0d/%b/%0d/%0d expected 0/0000/0/0",
                                 db_estado, leds, rodada, mem_endereco);
        end
    endtask

    initial begin
        test_reset();
        test_modo0_win();
        test_erro();
        test_timeout();
        test_modo1();
        test_ignore();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/controle_jogo_seq.md
Name: controle_jogo_seq

Overview:
- Parametrised control unit for the sequence-memory game (Genius-style), successor of the fixed-size control unit.
- Absorbs the round, address, LED and timeout counters. Drives an external sequence memory and the LED bank. Receives debounced button plays from the datapath.
- Adds configurable sequence length, LED on/gap timing and play timeout. Adds a "player-writes" mode in which each new move is entered by the player and stored in memory.

Parameters:
N_ROUNDS, 16, maximum sequence length (>=2); game is won after round N_ROUNDS-1
ADDR_W, 4, address/round counter width; must equal $clog2(N_ROUNDS)
DATA_W, 4, button/LED/memory word width (one-hot button code)
LED_ON_CYCLES, 1000, cycles each sequence element is lit (>=1)
LED_GAP_CYCLES, 250, dark cycles after each lit element (>=1)
TIMEOUT_CYCLES, 5000, cycles allowed per play in ESPERA/ESPERA_NOVA (>=2)

Ports:
clock  in  1  system clock, rising edge
reset  in  1  synchronous, active-high; sampled on clock rising edge
iniciar  in  1  start/restart request
modo  in  1  0 = sequence read from memory; 1 = player appends each new element; latched in PREPARA
jogada  in  1  one-cycle pulse: a button play is valid this cycle
botoes  in  DATA_W  button code, valid when jogada=1
mem_dado  in  DATA_W  memory read data at mem_endereco, combinational, same cycle
mem_endereco  out  ADDR_W  memory address (= address counter)
mem_escreve  out  1  memory write strobe, one cycle
mem_dado_escrita  out  DATA_W  write data (= play register)
leds  out  DATA_W  LED drive
rodada  out  ADDR_W  current round r; sequence length is r+1
acertou  out  1  high in ACERTO
errou  out  1  high in ERRO and TIMEOUT
timeout_flag  out  1  high in TIMEOUT
pronto  out  1  high in ACERTO, ERRO, TIMEOUT
db_estado  out  4  current state code

Behaviour:
- Reset: state INICIAL. Round, address, timer and play register are 0. All outputs are 0. db_estado=0.
- Clock, reset and outputs:
  - One clock; reset is synchronous and active-high.
  - All outputs are Moore, decoded from state and registers. Exception: leds=mem_dado in MOSTRA_LED. leds=0 in every other state.
- Timer:
  - Width is $clog2 of the largest cycle parameter.
  - Cleared on every state entry that uses it.
- State codes:
  - INICIAL 0, PREPARA 1, INICIA_RODADA 2, MOSTRA_LED 3, INTERVALO 4, ESPERA 5, COMPARA 6, PROXIMA 7.
  - FIM_RODADA 8, ESPERA_NOVA 9, GRAVA 10, TIMEOUT 13, ERRO 14, ACERTO 15.
  - Unused codes go to INICIAL.
- INICIAL: iniciar -> PREPARA.
- PREPARA:
  - Sets r=0, address=0, play register=0; latches modo.
  - modo=0 -> INICIA_RODADA; modo=1 -> ESPERA_NOVA.
- INICIA_RODADA: address=0, timer=0 -> MOSTRA_LED.
- MOSTRA_LED:
  - Timer counts. When timer==LED_ON_CYCLES-1 -> INTERVALO, timer cleared.
  - Each element is lit for exactly LED_ON_CYCLES cycles.
- INTERVALO:
  - When timer==LED_GAP_CYCLES-1: if address==r -> ESPERA (address=0, timer=0); else address+1 -> MOSTRA_LED.
- ESPERA:
  - jogada=1 -> play register<=botoes -> COMPARA.
  - Otherwise, when timer==TIMEOUT_CYCLES-1 -> TIMEOUT.
  - If jogada and terminal count coincide, jogada wins.
- COMPARA:
  - play register==mem_dado and address==r -> FIM_RODADA.
  - Equal and address<r -> PROXIMA.
  - Unequal -> ERRO.
- PROXIMA: address+1, timer=0 -> ESPERA.
- FIM_RODADA:
  - r==N_ROUNDS-1 -> ACERTO (r holds).
  - Else r+1, then modo=0 -> INICIA_RODADA; modo=1 -> ESPERA_NOVA.
- ESPERA_NOVA:
  - On entry: address=r, timer=0.
  - jogada -> play register<=botoes -> GRAVA.
  - Same timeout rule as ESPERA -> TIMEOUT.
- GRAVA: mem_escreve=1 for exactly this cycle at address r with data = play register -> INICIA_RODADA.
- ACERTO / ERRO / TIMEOUT: hold outputs; iniciar -> PREPARA.
- jogada is ignored outside ESPERA/ESPERA_NOVA.
- iniciar is ignored outside INICIAL/ACERTO/ERRO/TIMEOUT.
- Counters do not wrap: address never exceeds r; r never exceeds N_ROUNDS-1.
- reset in any state returns to INICIAL at the next edge with all outputs 0.

Test Plan:
(Params N_ROUNDS=4, LED_ON_CYCLES=3, LED_GAP_CYCLES=2, TIMEOUT_CYCLES=10, DATA_W=4.)
1. Reset held 2 cycles -> all outputs 0, db_estado=0, mem_escreve=0.
2. modo=0, memory {0001,0010,0100,1000}, iniciar, all plays correct:
   - LED windows total 1+2+3+4=10, each 3 cycles on, then 2 cycles dark.
   - Final state: acertou=1, pronto=1, rodada=3, db_estado=15.
3. modo=0, round 2, address 1: play 0100 (expected 0010) -> db_estado=14, errou=1, pronto=1, rodada=2; then iniciar -> PREPARA, rodada=0.
4. Timeout:
   - No jogada for 10 cycles in ESPERA -> db_estado=13, timeout_flag=1, errou=1.
   - Rerun with jogada on the 10th cycle -> COMPARA, no timeout.
5. modo=1: play 0010 in ESPERA_NOVA -> one-cycle mem_escreve with mem_endereco=0, mem_dado_escrita=0010. Then LED shows 0010 for 3 cycles. Correct repeat -> ESPERA_NOVA with mem_endereco=1, rodada=1.
6. Invalid and mid-operation inputs:
   - jogada during MOSTRA_LED -> ignored, no state change.
   - iniciar during ESPERA -> ignored.
   - reset during MOSTRA_LED -> INICIAL next edge, leds=0.
